// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - EX forwarding, load-use stall and data-memory freeze controller
//
// Purpose:
//   Tracks destination info of the instructions in EX, MEM and WB in a private
//   shadow pipeline and derives from it the EX operand forwarding selects, the
//   ID-stage write-through selects, the load-use stall/bubble controls and a
//   whole-pipeline freeze for data-memory loads that take more than one cycle.
//
// Ports:
//   clk_i          clock, all state updates on the rising edge
//   rst_n          asynchronous active-low reset
//   id_rs_i        rs of the instruction in ID
//   id_rt_i        rt of the instruction in ID
//   id_use_rs_i    ID instruction reads rs
//   id_use_rt_i    ID instruction reads rt
//   id_valid_i     ID holds a real instruction
//   id_rd_i        destination register of the ID instruction
//   id_regwrite_i  ID instruction writes the register file
//   id_memread_i   ID instruction is a load
//   fwd_a_o        EX operand A select: 00 register file, 01 MEM_WB, 10 EX_MEM
//   fwd_b_o        EX operand B select, same encoding
//   id_byp_a_o     ID rs read takes the WB write data
//   id_byp_b_o     ID rt read takes the WB write data
//   stall_id_o     hold PC and IF_ID
//   bubble_ex_o    zero the ID_EX control bits
//   freeze_o       hold every pipeline register

module fwd_hazard_unit #(
  parameter int ADDR_W    = 5,
  parameter int LOAD_LAT  = 1,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] id_rs_i,
  input  logic [ADDR_W-1:0] id_rt_i,
  input  logic              id_use_rs_i,
  input  logic              id_use_rt_i,
  input  logic              id_valid_i,
  input  logic [ADDR_W-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              id_byp_a_o,
  output logic              id_byp_b_o,
  output logic              stall_id_o,
  output logic              bubble_ex_o,
  output logic              freeze_o
);

  // The freeze counter runs 1..LOAD_LAT-1; LOAD_LAT is at most 15.
  localparam logic [3:0] FREEZE_LAST = 4'(LOAD_LAT - 1);
  localparam bit         MULTI_CYCLE = (LOAD_LAT > 1);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic              regwrite;
    logic              memread;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic              use_rs;
    logic              use_rt;
  } ex_slot_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic              regwrite;
    logic              memread;
  } mw_slot_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  ex_slot_t   ex_q;
  mw_slot_t   mem_q;
  mw_slot_t   wb_q;
  state_t     state_q;
  state_t     state_d;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic       freeze;
  logic       lu;

  // The WB slot carries memread only so that all slots shift the same record.
  logic unused_wb_memread;
  assign unused_wb_memread = wb_q.memread;

  // A slot "writes r" when it will commit to r; register 0 is never a producer.
  function automatic logic writes(input logic              valid,
                                  input logic              regwrite,
                                  input logic [ADDR_W-1:0] rd,
                                  input logic [ADDR_W-1:0] r);
    return valid && regwrite && (rd == r) && (r != '0);
  endfunction

  // ------------------------------------------------------------------
  // Memory freeze FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The load sits in MEM for LOAD_LAT cycles: LOAD_LAT-1 frozen ones plus the
  // final cycle in which the pipeline advances. Returning to IDLE only after
  // that advance keeps the same load from triggering a second freeze, while
  // a following load that lands in MEM is seen fresh in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    freeze  = 1'b0;
    case (state_q)
      IDLE: begin
        if (MULTI_CYCLE && mem_q.valid && mem_q.memread) begin
          freeze  = 1'b1;
          cnt_d   = 4'd1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != FREEZE_LAST) begin
          freeze = 1'b1;
          cnt_d  = cnt_q + 4'd1;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Load-use detection against the (possibly held) EX slot
  // ------------------------------------------------------------------
  assign lu = id_valid_i && ex_q.valid && ex_q.memread && (ex_q.rd != '0) &&
              ((id_use_rs_i && (ex_q.rd == id_rs_i)) ||
               (id_use_rt_i && (ex_q.rd == id_rt_i)));

  assign freeze_o    = freeze;
  assign stall_id_o  = freeze || lu;
  assign bubble_ex_o = !freeze && lu;

  // ------------------------------------------------------------------
  // EX forwarding selects; the younger producer in MEM wins over WB, but a
  // load in MEM has no data yet so it never forwards from EX_MEM.
  // ------------------------------------------------------------------
  always_comb begin
    fwd_a_o = 2'b00;
    fwd_b_o = 2'b00;
    if (ex_q.valid && ex_q.use_rs) begin
      if (writes(mem_q.valid, mem_q.regwrite, mem_q.rd, ex_q.rs) && !mem_q.memread) begin
        fwd_a_o = 2'b10;
      end else if (writes(wb_q.valid, wb_q.regwrite, wb_q.rd, ex_q.rs)) begin
        fwd_a_o = 2'b01;
      end
    end
    if (ex_q.valid && ex_q.use_rt) begin
      if (writes(mem_q.valid, mem_q.regwrite, mem_q.rd, ex_q.rt) && !mem_q.memread) begin
        fwd_b_o = 2'b10;
      end else if (writes(wb_q.valid, wb_q.regwrite, wb_q.rd, ex_q.rt)) begin
        fwd_b_o = 2'b01;
      end
    end
  end

  // ID-stage write-through covers the register file's read-before-write window.
  assign id_byp_a_o = WB_BYPASS && id_use_rs_i &&
                      writes(wb_q.valid, wb_q.regwrite, wb_q.rd, id_rs_i);
  assign id_byp_b_o = WB_BYPASS && id_use_rt_i &&
                      writes(wb_q.valid, wb_q.regwrite, wb_q.rd, id_rt_i);

  // ------------------------------------------------------------------
  // Shadow pipeline
  // ------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!freeze) begin
      wb_q           <= mem_q;
      mem_q.valid    <= ex_q.valid;
      mem_q.rd       <= ex_q.rd;
      mem_q.regwrite <= ex_q.regwrite;
      mem_q.memread  <= ex_q.memread;
      if (lu) begin
        ex_q <= '0;
      end else begin
        ex_q.valid    <= id_valid_i;
        ex_q.rd       <= id_rd_i;
        ex_q.regwrite <= id_regwrite_i;
        ex_q.memread  <= id_memread_i;
        ex_q.rs       <= id_rs_i;
        ex_q.rt       <= id_rt_i;
        ex_q.use_rs   <= id_use_rs_i;
        ex_q.use_rt   <= id_use_rt_i;
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - directed self-checking bench for fwd_hazard_unit
//
// Four instances share the stimulus:
//   [0] LOAD_LAT=1, WB_BYPASS=1   [1] LOAD_LAT=3, WB_BYPASS=1
//   [2] LOAD_LAT=4, WB_BYPASS=1   [3] LOAD_LAT=1, WB_BYPASS=0

module tb_fwd_hazard_unit;

  localparam int N = 4;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic       id_valid;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       id_memread;

  logic [1:0] fwd_a  [N];
  logic [1:0] fwd_b  [N];
  logic       byp_a  [N];
  logic       byp_b  [N];
  logic       stall  [N];
  logic       bubble [N];
  logic       freeze [N];
  logic [8:0] ov     [N];

  int passed;
  int total;

  for (genvar g = 0; g < N; g++) begin : g_dut
    fwd_hazard_unit #(
      .ADDR_W   (5),
      .LOAD_LAT ((g == 1) ? 3 : ((g == 2) ? 4 : 1)),
      .WB_BYPASS(g != 3)
    ) u_dut (
      .clk_i        (clk),
      .rst_n        (rst_n),
      .id_rs_i      (id_rs),
      .id_rt_i      (id_rt),
      .id_use_rs_i  (id_use_rs),
      .id_use_rt_i  (id_use_rt),
      .id_valid_i   (id_valid),
      .id_rd_i      (id_rd),
      .id_regwrite_i(id_regwrite),
      .id_memread_i (id_memread),
      .fwd_a_o      (fwd_a[g]),
      .fwd_b_o      (fwd_b[g]),
      .id_byp_a_o   (byp_a[g]),
      .id_byp_b_o   (byp_b[g]),
      .stall_id_o   (stall[g]),
      .bubble_ex_o  (bubble[g]),
      .freeze_o     (freeze[g])
    );
    assign ov[g] = {fwd_a[g], fwd_b[g], byp_a[g], byp_b[g], stall[g], bubble[g], freeze[g]};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] rd,
                        input logic rw, input logic mr);
    id_valid    = v;
    id_rs       = rs;
    id_rt       = rt;
    id_use_rs   = urs;
    id_use_rt   = urt;
    id_rd       = rd;
    id_regwrite = rw;
    id_memread  = mr;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    nop();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_id(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1);
    #1;
    for (int i = 0; i < N; i++) begin
      total++; if (ov[i] !== 9'd0) $display("FAIL reset_hold[%0d]: got %b exp %b", i, ov[i], 9'd0); else passed++;
    end
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      total++; if (ov[i] !== 9'd0) $display("FAIL reset_first_cycle[%0d]: got %b exp %b", i, ov[i], 9'd0); else passed++;
    end
  endtask

  task automatic test_fwd_basic();
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);   // add r3=r1+r2
    tick();
    set_id(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);   // sub r4=r3-r5
    tick();
    set_id(1'b1, 5'd3, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);   // or r6=r3|r0
    #1;
    total++; if (fwd_a[0] !== 2'b10) $display("FAIL exmem_fwd_a: got %b exp %b", fwd_a[0], 2'b10); else passed++;
    total++; if (fwd_b[0] !== 2'b00) $display("FAIL exmem_fwd_b: got %b exp %b", fwd_b[0], 2'b00); else passed++;
    total++; if (stall[0] !== 1'b0) $display("FAIL exmem_stall: got %b exp %b", stall[0], 1'b0); else passed++;
    tick();
    set_id(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);  // and r10=r3&r4
    #1;
    total++; if (fwd_a[0] !== 2'b01) $display("FAIL memwb_fwd_a: got %b exp %b", fwd_a[0], 2'b01); else passed++;
    total++; if (fwd_b[0] !== 2'b00) $display("FAIL memwb_fwd_b_r0: got %b exp %b", fwd_b[0], 2'b00); else passed++;
    total++; if (byp_a[0] !== 1'b1) $display("FAIL wb_byp_a: got %b exp %b", byp_a[0], 1'b1); else passed++;
    total++; if (byp_b[0] !== 1'b0) $display("FAIL wb_byp_b: got %b exp %b", byp_b[0], 1'b0); else passed++;
    total++; if (byp_a[3] !== 1'b0) $display("FAIL byp_disabled: got %b exp %b", byp_a[3], 1'b0); else passed++;
  endtask

  task automatic test_double_match();
    do_reset();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0);
    #1;
    total++; if (fwd_a[0] !== 2'b10) $display("FAIL double_fwd_a: got %b exp %b", fwd_a[0], 2'b10); else passed++;
    total++; if (fwd_b[0] !== 2'b10) $display("FAIL double_fwd_b: got %b exp %b", fwd_b[0], 2'b10); else passed++;
    total++; if (byp_a[0] !== 1'b1) $display("FAIL double_byp_a: got %b exp %b", byp_a[0], 1'b1); else passed++;
    total++; if (byp_b[0] !== 1'b1) $display("FAIL double_byp_b: got %b exp %b", byp_b[0], 1'b1); else passed++;
    total++; if (byp_b[3] !== 1'b0) $display("FAIL double_byp_disabled: got %b exp %b", byp_b[3], 1'b0); else passed++;
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);   // lw r8
    tick();
    set_id(1'b1, 5'd2, 5'd8, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0);  // add r13=r2+r8
    #1;
    total++; if (stall[0] !== 1'b1) $display("FAIL lu_stall: got %b exp %b", stall[0], 1'b1); else passed++;
    total++; if (bubble[0] !== 1'b1) $display("FAIL lu_bubble: got %b exp %b", bubble[0], 1'b1); else passed++;
    total++; if (freeze[0] !== 1'b0) $display("FAIL lu_freeze: got %b exp %b", freeze[0], 1'b0); else passed++;
    tick();
    #1;
    total++; if (stall[0] !== 1'b0) $display("FAIL lu_one_cycle_stall: got %b exp %b", stall[0], 1'b0); else passed++;
    total++; if (bubble[0] !== 1'b0) $display("FAIL lu_one_cycle_bubble: got %b exp %b", bubble[0], 1'b0); else passed++;
    tick();
    nop();
    #1;
    total++; if (fwd_b[0] !== 2'b01) $display("FAIL lu_after_fwd_b: got %b exp %b", fwd_b[0], 2'b01); else passed++;
    total++; if (fwd_a[0] !== 2'b00) $display("FAIL lu_after_fwd_a: got %b exp %b", fwd_a[0], 2'b00); else passed++;

    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd2, 5'd8, 1'b1, 1'b0, 5'd13, 1'b1, 1'b0);  // rt=r8 but not read
    #1;
    total++; if (stall[0] !== 1'b0) $display("FAIL lu_unused_rt: got %b exp %b", stall[0], 1'b0); else passed++;
    set_id(1'b1, 5'd8, 5'd2, 1'b1, 1'b0, 5'd13, 1'b1, 1'b0);  // reads r8 on rs
    #1;
    total++; if (stall[0] !== 1'b1) $display("FAIL lu_rs: got %b exp %b", stall[0], 1'b1); else passed++;
    set_id(1'b0, 5'd8, 5'd2, 1'b1, 1'b0, 5'd13, 1'b1, 1'b0);  // ID not valid
    #1;
    total++; if (stall[0] !== 1'b0) $display("FAIL lu_id_invalid: got %b exp %b", stall[0], 1'b0); else passed++;

    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);   // lw r0
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0);
    #1;
    total++; if (stall[0] !== 1'b0) $display("FAIL lu_r0: got %b exp %b", stall[0], 1'b0); else passed++;
  endtask

  task automatic test_freeze();
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd14, 1'b1, 1'b1);  // lw r14
    tick();
    nop();
    #1;
    total++; if (freeze[2] !== 1'b0) $display("FAIL frz_before_mem: got %b exp %b", freeze[2], 1'b0); else passed++;
    tick();
    set_id(1'b1, 5'd14, 5'd1, 1'b1, 1'b1, 5'd15, 1'b1, 1'b0); // add r15=r14+r1
    for (int c = 0; c < 4; c++) begin
      #1;
      total++;
      if (freeze[2] !== (c < 3)) $display("FAIL frz_ll4_cycle%0d: got %b exp %b", c, freeze[2], (c < 3));
      else passed++;
      if (c == 0) begin
        total++; if (stall[2] !== 1'b1) $display("FAIL frz_stall: got %b exp %b", stall[2], 1'b1); else passed++;
        total++; if (bubble[2] !== 1'b0) $display("FAIL frz_bubble: got %b exp %b", bubble[2], 1'b0); else passed++;
        total++; if (freeze[0] !== 1'b0) $display("FAIL frz_ll1_never: got %b exp %b", freeze[0], 1'b0); else passed++;
      end
      tick();
    end
    nop();
    #1;
    total++; if (freeze[2] !== 1'b0) $display("FAIL frz_idle_after: got %b exp %b", freeze[2], 1'b0); else passed++;
    total++; if (fwd_a[2] !== 2'b01) $display("FAIL frz_shift_fwd_a: got %b exp %b", fwd_a[2], 2'b01); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [5:0] pat;
    pat = 6'b011011;                                           // cycle 0 in bit 0
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd16, 1'b1, 1'b1);  // lw r16
    tick();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd17, 1'b1, 1'b1);  // lw r17
    tick();
    nop();
    for (int c = 0; c < 6; c++) begin
      #1;
      total++;
      if (freeze[1] !== pat[c]) $display("FAIL b2b_ll3_cycle%0d: got %b exp %b", c, freeze[1], pat[c]);
      else passed++;
      tick();
    end
  endtask

  task automatic test_load_use_freeze();
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1);   // lw r9
    tick();
    set_id(1'b1, 5'd9, 5'd2, 1'b1, 1'b1, 5'd18, 1'b1, 1'b0);  // add r18=r9+r2
    #1;
    total++; if ({stall[1], bubble[1], freeze[1]} !== 3'b110) $display("FAIL luf_stall: got %b exp %b", {stall[1], bubble[1], freeze[1]}, 3'b110); else passed++;
    tick();
    #1;
    total++; if ({stall[1], bubble[1], freeze[1]} !== 3'b101) $display("FAIL luf_frz1: got %b exp %b", {stall[1], bubble[1], freeze[1]}, 3'b101); else passed++;
    tick();
    #1;
    total++; if ({stall[1], bubble[1], freeze[1]} !== 3'b101) $display("FAIL luf_frz2: got %b exp %b", {stall[1], bubble[1], freeze[1]}, 3'b101); else passed++;
    tick();
    #1;
    total++; if ({stall[1], bubble[1], freeze[1]} !== 3'b000) $display("FAIL luf_release: got %b exp %b", {stall[1], bubble[1], freeze[1]}, 3'b000); else passed++;
    tick();
    nop();
    #1;
    total++; if (fwd_a[1] !== 2'b01) $display("FAIL luf_fwd_a: got %b exp %b", fwd_a[1], 2'b01); else passed++;
    total++; if (fwd_b[1] !== 2'b00) $display("FAIL luf_fwd_b: got %b exp %b", fwd_b[1], 2'b00); else passed++;
    total++; if (stall[1] !== 1'b0) $display("FAIL luf_no_restall: got %b exp %b", stall[1], 1'b0); else passed++;
  endtask

  task automatic test_r0_and_reset();
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);   // addi r0
    tick();
    nop();
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd19, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd20, 1'b1, 1'b0);
    #1;
    total++; if (fwd_a[0] !== 2'b00) $display("FAIL r0_fwd_a: got %b exp %b", fwd_a[0], 2'b00); else passed++;
    total++; if (fwd_b[0] !== 2'b00) $display("FAIL r0_fwd_b: got %b exp %b", fwd_b[0], 2'b00); else passed++;
    total++; if (byp_a[0] !== 1'b0) $display("FAIL r0_byp_a: got %b exp %b", byp_a[0], 1'b0); else passed++;
    total++; if (byp_b[0] !== 1'b0) $display("FAIL r0_byp_b: got %b exp %b", byp_b[0], 1'b0); else passed++;

    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd20, 1'b1, 1'b1);  // lw r20
    tick();
    nop();
    tick();
    #1;
    total++; if (freeze[2] !== 1'b1) $display("FAIL mrst_frz1: got %b exp %b", freeze[2], 1'b1); else passed++;
    tick();
    #1;
    total++; if (freeze[2] !== 1'b1) $display("FAIL mrst_frz2: got %b exp %b", freeze[2], 1'b1); else passed++;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      total++; if (ov[i] !== 9'd0) $display("FAIL mrst_async[%0d]: got %b exp %b", i, ov[i], 9'd0); else passed++;
    end
    tick();
    rst_n = 1'b1;
    #1;
    total++; if (ov[2] !== 9'd0) $display("FAIL mrst_release: got %b exp %b", ov[2], 9'd0); else passed++;
    tick();
    #1;
    total++; if (ov[2] !== 9'd0) $display("FAIL mrst_after_ll4: got %b exp %b", ov[2], 9'd0); else passed++;
    total++; if (ov[1] !== 9'd0) $display("FAIL mrst_after_ll3: got %b exp %b", ov[1], 9'd0); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst_n  = 1'b0;
    nop();
    test_reset();
    test_fwd_basic();
    test_double_match();
    test_load_use();
    test_freeze();
    test_back_to_back();
    test_load_use_freeze();
    test_r0_and_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
